// File: rtl/qdrc_arb.sv
// rtl/qdrc_arb.sv - two-requester round-robin arbiter for the QDR controller read/write channels
// Read tags are tracked in a small FIFO so returns are steered back to the issuing requester.
module qdrc_arb #(
   parameter int DATA_WIDTH = 36,
   parameter int ADDR_WIDTH = 21,
   parameter int TAG_DEPTH  = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    phy_rdy,
   input  logic                    a_rd_req,
   input  logic                    b_rd_req,
   input  logic                    a_wr_req,
   input  logic                    b_wr_req,
   input  logic [ADDR_WIDTH-1:0]   a_addr,
   input  logic [ADDR_WIDTH-1:0]   b_addr,
   input  logic [2*DATA_WIDTH-1:0] a_wr_data,
   input  logic [2*DATA_WIDTH-1:0] b_wr_data,
   output logic                    a_rd_ack,
   output logic                    b_rd_ack,
   output logic                    a_wr_ack,
   output logic                    b_wr_ack,
   output logic [2*DATA_WIDTH-1:0] rd_data,
   output logic                    a_rd_dvld,
   output logic                    b_rd_dvld,
   output logic                    qdr_rd_strb,
   output logic                    qdr_wr_strb,
   output logic [ADDR_WIDTH-1:0]   qdr_rd_addr,
   output logic [ADDR_WIDTH-1:0]   qdr_wr_addr,
   output logic [2*DATA_WIDTH-1:0] qdr_wr_data,
   input  logic [2*DATA_WIDTH-1:0] qdr_rd_data,
   input  logic                    qdr_rd_dvld,
   output logic                    tag_err
);
   localparam int PW = $clog2(TAG_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(TAG_DEPTH);

   // lp = 1 means B was granted last
   logic                    rd_busy_q, wr_busy_q, rd_lp_q, wr_lp_q;
   logic                    rd_strb_q, wr_strb_q;
   logic [ADDR_WIDTH-1:0]   rd_addr_q, wr_addr_q;
   logic [2*DATA_WIDTH-1:0] wr_data_q, rd_data_q;
   logic                    a_dvld_q, b_dvld_q, tag_err_q;
   logic [CW-1:0]           tag_count_q, tag_count_d;
   logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
   logic                    tag_mem_q [TAG_DEPTH];

   logic rd_gnt, rd_sel_b, wr_gnt, wr_sel_b, fifo_empty, pop, head_tag;

   always_comb begin
      fifo_empty = (tag_count_q == '0);
      pop        = qdr_rd_dvld & ~fifo_empty;
      head_tag   = tag_mem_q[rd_ptr_q];
      // full check uses the count before any same-cycle pop
      rd_gnt     = phy_rdy & ~rd_busy_q & (a_rd_req | b_rd_req) & (tag_count_q < DEPTH_C);
      rd_sel_b   = b_rd_req & (~a_rd_req | ~rd_lp_q);
      wr_gnt     = phy_rdy & ~wr_busy_q & (a_wr_req | b_wr_req);
      wr_sel_b   = b_wr_req & (~a_wr_req | ~wr_lp_q);
      tag_count_d = tag_count_q;
      if (rd_gnt && !pop)
         tag_count_d = tag_count_q + CW'(1);
      else if (!rd_gnt && pop)
         tag_count_d = tag_count_q - CW'(1);
   end

   assign a_rd_ack    = rd_gnt & ~rd_sel_b;
   assign b_rd_ack    = rd_gnt & rd_sel_b;
   assign a_wr_ack    = wr_gnt & ~wr_sel_b;
   assign b_wr_ack    = wr_gnt & wr_sel_b;
   assign qdr_rd_strb = rd_strb_q;
   assign qdr_wr_strb = wr_strb_q;
   assign qdr_rd_addr = rd_addr_q;
   assign qdr_wr_addr = wr_addr_q;
   assign qdr_wr_data = wr_data_q;
   assign rd_data     = rd_data_q;
   assign a_rd_dvld   = a_dvld_q;
   assign b_rd_dvld   = b_dvld_q;
   assign tag_err     = tag_err_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_busy_q   <= 1'b0;
         wr_busy_q   <= 1'b0;
         rd_lp_q     <= 1'b1;
         wr_lp_q     <= 1'b1;
         rd_strb_q   <= 1'b0;
         wr_strb_q   <= 1'b0;
         rd_addr_q   <= '0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         rd_data_q   <= '0;
         a_dvld_q    <= 1'b0;
         b_dvld_q    <= 1'b0;
         tag_err_q   <= 1'b0;
         tag_count_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
      end else begin
         rd_busy_q <= rd_gnt;
         wr_busy_q <= wr_gnt;
         rd_strb_q <= rd_gnt;
         wr_strb_q <= wr_gnt;
         if (rd_gnt) begin
            rd_lp_q   <= rd_sel_b;
            rd_addr_q <= rd_sel_b ? b_addr : a_addr;
            wr_ptr_q  <= wr_ptr_q + PW'(1);
         end
         if (wr_gnt) begin
            wr_lp_q   <= wr_sel_b;
            wr_addr_q <= wr_sel_b ? b_addr : a_addr;
            wr_data_q <= wr_sel_b ? b_wr_data : a_wr_data;
         end
         if (pop) begin
            rd_ptr_q  <= rd_ptr_q + PW'(1);
            rd_data_q <= qdr_rd_data;
         end
         a_dvld_q    <= pop & ~head_tag;
         b_dvld_q    <= pop & head_tag;
         tag_count_q <= tag_count_d;
         if (qdr_rd_dvld && fifo_empty)
            tag_err_q <= 1'b1;
      end
   end

   // tag storage needs no reset; the pointers define what is valid
   always_ff @(posedge clk) begin
      if (rd_gnt)
         tag_mem_q[wr_ptr_q] <= rd_sel_b;
   end
endmodule

// File: tb/tb_qdrc_arb.sv
// tb/tb_qdrc_arb.sv - scoreboard bench for qdrc_arb
// Stimulus pushes expected acks/strobes/returns; a negedge monitor pops and compares.
module tb_qdrc_arb;
   localparam int DW = 36;
   localparam int AW = 21;
   localparam int TD = 16;

   logic clk = 1'b0, reset = 1'b1, phy_rdy = 1'b1;
   logic a_rd_req = 1'b0, b_rd_req = 1'b0, a_wr_req = 1'b0, b_wr_req = 1'b0;
   logic [AW-1:0] a_addr = '0, b_addr = '0;
   logic [2*DW-1:0] a_wr_data = '0, b_wr_data = '0, qdr_rd_data = '0;
   logic qdr_rd_dvld = 1'b0;
   logic a_rd_ack, b_rd_ack, a_wr_ack, b_wr_ack, a_rd_dvld, b_rd_dvld;
   logic qdr_rd_strb, qdr_wr_strb, tag_err;
   logic [2*DW-1:0] rd_data, qdr_wr_data;
   logic [AW-1:0] qdr_rd_addr, qdr_wr_addr;

   qdrc_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_DEPTH(TD)) dut (
      .clk(clk), .reset(reset), .phy_rdy(phy_rdy),
      .a_rd_req(a_rd_req), .b_rd_req(b_rd_req), .a_wr_req(a_wr_req), .b_wr_req(b_wr_req),
      .a_addr(a_addr), .b_addr(b_addr), .a_wr_data(a_wr_data), .b_wr_data(b_wr_data),
      .a_rd_ack(a_rd_ack), .b_rd_ack(b_rd_ack), .a_wr_ack(a_wr_ack), .b_wr_ack(b_wr_ack),
      .rd_data(rd_data), .a_rd_dvld(a_rd_dvld), .b_rd_dvld(b_rd_dvld),
      .qdr_rd_strb(qdr_rd_strb), .qdr_wr_strb(qdr_wr_strb),
      .qdr_rd_addr(qdr_rd_addr), .qdr_wr_addr(qdr_wr_addr), .qdr_wr_data(qdr_wr_data),
      .qdr_rd_data(qdr_rd_data), .qdr_rd_dvld(qdr_rd_dvld), .tag_err(tag_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int              cyc;
      logic [1:0]      who;
      logic [AW-1:0]   addr;
      logic [2*DW-1:0] data;
   } exp_t;

   exp_t rd_ack_q[$], wr_ack_q[$], rd_strb_q[$], wr_strb_q[$], ret_q[$];
   int vectors = 0;
   int miscompares = 0;

   task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic unexpected(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s at cycle %0d: got an event, expected none", name, cyc);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (a_rd_ack || b_rd_ack) begin
         if (rd_ack_q.size() == 0) unexpected("rd_ack");
         else begin
            e = rd_ack_q.pop_front();
            cmp("rd_ack_cyc", 128'(cyc), 128'(e.cyc));
            cmp("rd_ack_who", 128'({b_rd_ack, a_rd_ack}), 128'(e.who));
         end
      end
      if (a_wr_ack || b_wr_ack) begin
         if (wr_ack_q.size() == 0) unexpected("wr_ack");
         else begin
            e = wr_ack_q.pop_front();
            cmp("wr_ack_cyc", 128'(cyc), 128'(e.cyc));
            cmp("wr_ack_who", 128'({b_wr_ack, a_wr_ack}), 128'(e.who));
         end
      end
      if (qdr_rd_strb) begin
         if (rd_strb_q.size() == 0) unexpected("rd_strb");
         else begin
            e = rd_strb_q.pop_front();
            cmp("rd_strb_cyc", 128'(cyc), 128'(e.cyc));
            cmp("rd_strb_addr", 128'(qdr_rd_addr), 128'(e.addr));
         end
      end
      if (qdr_wr_strb) begin
         if (wr_strb_q.size() == 0) unexpected("wr_strb");
         else begin
            e = wr_strb_q.pop_front();
            cmp("wr_strb_cyc", 128'(cyc), 128'(e.cyc));
            cmp("wr_strb_addr", 128'(qdr_wr_addr), 128'(e.addr));
            cmp("wr_strb_data", 128'(qdr_wr_data), 128'(e.data));
         end
      end
      if (a_rd_dvld || b_rd_dvld) begin
         if (ret_q.size() == 0) unexpected("rd_dvld");
         else begin
            e = ret_q.pop_front();
            cmp("ret_cyc", 128'(cyc), 128'(e.cyc));
            cmp("ret_who", 128'({b_rd_dvld, a_rd_dvld}), 128'(e.who));
            cmp("ret_data", 128'(rd_data), 128'(e.data));
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
   endtask

   task automatic exp_rd(input int c, input logic [1:0] who, input logic [AW-1:0] addr);
      exp_t e;
      e.cyc = c; e.who = who; e.addr = addr; e.data = '0;
      rd_ack_q.push_back(e);
      e.cyc = c + 1;
      rd_strb_q.push_back(e);
   endtask

   task automatic exp_wr(input int c, input logic [1:0] who, input logic [AW-1:0] addr,
                         input logic [2*DW-1:0] data);
      exp_t e;
      e.cyc = c; e.who = who; e.addr = addr; e.data = data;
      wr_ack_q.push_back(e);
      e.cyc = c + 1;
      wr_strb_q.push_back(e);
   endtask

   // drives one controller return in the current cycle and expects it next cycle
   task automatic ret(input logic [1:0] who, input logic [2*DW-1:0] data);
      exp_t e;
      e.cyc = cyc + 1; e.who = who; e.addr = '0; e.data = data;
      ret_q.push_back(e);
      qdr_rd_dvld = 1'b1;
      qdr_rd_data = data;
      tick();
      qdr_rd_dvld = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      // reset state
      do_reset();
      @(negedge clk);
      cmp("rst_rd_strb", 128'(qdr_rd_strb), 128'(0));
      cmp("rst_wr_strb", 128'(qdr_wr_strb), 128'(0));
      cmp("rst_rd_addr", 128'(qdr_rd_addr), 128'(0));
      cmp("rst_wr_addr", 128'(qdr_wr_addr), 128'(0));
      cmp("rst_wr_data", 128'(qdr_wr_data), 128'(0));
      cmp("rst_rd_data", 128'(rd_data), 128'(0));
      cmp("rst_dvld", 128'({a_rd_dvld, b_rd_dvld}), 128'(0));
      cmp("rst_tag_err", 128'(tag_err), 128'(0));
      tick();

      // single read from A
      a_addr = 21'h00010;
      a_rd_req = 1'b1;
      exp_rd(cyc, 2'b01, 21'h00010);
      tick();
      a_rd_req = 1'b0;
      tick(3);
      ret(2'b01, 72'h123456789);
      tick(2);

      // round-robin contention on reads
      do_reset();
      a_addr = 21'h00100;
      b_addr = 21'h00200;
      a_rd_req = 1'b1;
      b_rd_req = 1'b1;
      k = cyc;
      for (int i = 0; i < 6; i++)
         exp_rd(k + 2*i, (i % 2 == 1) ? 2'b10 : 2'b01, (i % 2 == 1) ? 21'h00200 : 21'h00100);
      tick(12);
      a_rd_req = 1'b0;
      b_rd_req = 1'b0;
      tick(2);
      for (int i = 0; i < 6; i++)
         ret((i % 2 == 1) ? 2'b10 : 2'b01, 72'hD0 + 72'(i));
      tick(2);

      // concurrent channels: A writes while B reads
      do_reset();
      a_addr = 21'h0AAAA;
      a_wr_data = 72'hA5_1234_5678_9ABC_DEF0;
      b_addr = 21'h15555;
      a_wr_req = 1'b1;
      b_rd_req = 1'b1;
      exp_wr(cyc, 2'b01, 21'h0AAAA, 72'hA5_1234_5678_9ABC_DEF0);
      exp_rd(cyc, 2'b10, 21'h15555);
      tick();
      a_wr_req = 1'b0;
      b_rd_req = 1'b0;
      tick(2);
      ret(2'b10, 72'h5A_0F0F_0F0F_0F0F_0F0F);
      tick(2);

      // tag FIFO full: 16 grants, 17th waits for a pop
      do_reset();
      a_addr = 21'h00777;
      a_rd_req = 1'b1;
      k = cyc;
      for (int i = 0; i < TD; i++)
         exp_rd(k + 2*i, 2'b01, 21'h00777);
      tick(36);
      exp_rd(cyc + 1, 2'b01, 21'h00777);
      ret(2'b01, 72'hF00);
      tick();
      a_rd_req = 1'b0;
      for (int i = 0; i < TD; i++)
         ret(2'b01, 72'hE00 + 72'(i));
      tick(2);

      // phy_rdy gating
      do_reset();
      phy_rdy = 1'b0;
      a_addr = 21'h00033;
      b_addr = 21'h00044;
      b_wr_data = 72'h44_4444_4444;
      a_rd_req = 1'b1;
      b_wr_req = 1'b1;
      tick(5);
      phy_rdy = 1'b1;
      exp_rd(cyc, 2'b01, 21'h00033);
      exp_wr(cyc, 2'b10, 21'h00044, 72'h44_4444_4444);
      tick();
      a_rd_req = 1'b0;
      b_wr_req = 1'b0;
      tick(2);
      ret(2'b01, 72'h33);
      tick(2);

      // reset mid-operation flushes the FIFO; a late return is a tag error
      do_reset();
      a_addr = 21'h00055;
      a_rd_req = 1'b1;
      exp_rd(cyc, 2'b01, 21'h00055);
      tick();
      a_rd_req = 1'b0;
      tick(2);
      do_reset();
      @(negedge clk);
      cmp("tag_err_before", 128'(tag_err), 128'(0));
      tick();
      qdr_rd_dvld = 1'b1;
      qdr_rd_data = 72'hBAD;
      tick();
      qdr_rd_dvld = 1'b0;
      @(negedge clk);
      cmp("tag_err_set", 128'(tag_err), 128'(1));
      tick(3);
      @(negedge clk);
      cmp("tag_err_held", 128'(tag_err), 128'(1));
      tick();
      do_reset();
      @(negedge clk);
      cmp("tag_err_cleared", 128'(tag_err), 128'(0));
      tick(2);

      cmp("left_rd_ack", 128'(rd_ack_q.size()), 128'(0));
      cmp("left_wr_ack", 128'(wr_ack_q.size()), 128'(0));
      cmp("left_rd_strb", 128'(rd_strb_q.size()), 128'(0));
      cmp("left_wr_strb", 128'(wr_strb_q.size()), 128'(0));
      cmp("left_ret", 128'(ret_q.size()), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/qdrc_arb.md
# qdrc_arb

Two-port arbiter placed in front of the QDR controller. It shares the controller's independent read and write channels between requester A (fabric user) and requester B (CPU/bus bridge). Reads and writes are arbitrated separately with round-robin, and each channel issues at most one strobe every second cycle to match the controller's burst spacing. Read data is returned in order and steered to the correct requester by a tag FIFO.

## Interface
Parameters:
- DATA_WIDTH, 36, QDR word width; the data buses are 2*DATA_WIDTH wide.
- ADDR_WIDTH, 21, QDR burst address width.
- TAG_DEPTH, 16, maximum outstanding reads; must be a power of 2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- phy_rdy  in  1  controller calibrated; no grants while low.
- a_rd_req, b_rd_req  in  1  read request, held until ack.
- a_wr_req, b_wr_req  in  1  write request, held until ack.
- a_addr, b_addr  in  ADDR_WIDTH  request address, shared by rd and wr.
- a_wr_data, b_wr_data  in  2*DATA_WIDTH  write data.
- a_rd_ack, b_rd_ack, a_wr_ack, b_wr_ack  out  1  combinational grant, one cycle.
- rd_data  out  2*DATA_WIDTH  returned read data, broadcast to both requesters.
- a_rd_dvld, b_rd_dvld  out  1  rd_data valid for that requester.
- qdr_rd_strb, qdr_wr_strb  out  1  strobes to the controller, registered.
- qdr_rd_addr, qdr_wr_addr  out  ADDR_WIDTH  registered.
- qdr_wr_data  out  2*DATA_WIDTH  registered.
- qdr_rd_data  in  2*DATA_WIDTH  from the controller.
- qdr_rd_dvld  in  1  from the controller; returns in issue order.
- tag_err  out  1  sticky; qdr_rd_dvld arrived with the tag FIFO empty.

## Operation
- **Read and write channels.** The two channels are fully independent. A read grant and a write grant may occur in the same cycle. Both grants may go to the same requester.
- **Per-channel state.** Each channel holds a last-granted pointer (lp) and a busy flag.
  - busy is set the cycle after a grant and clears one cycle later.
  - No grant is made while busy=1.
- **Grant eligibility.** A grant requires all of: phy_rdy=1, busy=0, and at least one request.
- **Read-channel extra condition.** Read grants additionally require tag_count < TAG_DEPTH. This is checked before any same-cycle pop, so the check is conservative.
- **Round-robin.**
  - If both requesters request, grant the one that is not lp.
  - If one requests, grant it.
  - lp updates to the granted requester.
- **On a grant:**
  - The matching ack is asserted that cycle.
  - The address (and write data, for writes) is registered onto the qdr_* outputs.
  - The qdr strobe is asserted the next cycle for exactly one cycle.
- **Tag FIFO.** Width 1: 0=A, 1=B; depth TAG_DEPTH; pointers wrap modulo TAG_DEPTH.
  - Push on a read grant.
  - Pop on qdr_rd_dvld.
  - Simultaneous push and pop leaves tag_count unchanged.
- **Read return.** On qdr_rd_dvld with the FIFO not empty:
  - Register rd_data <= qdr_rd_data.
  - Assert a_rd_dvld or b_rd_dvld per the head tag.
- **Read return with FIFO empty.**
  - Data is dropped and neither dvld asserts.
  - tag_err is set and held until reset.
- **phy_rdy dropping low.**
  - New grants stop.
  - Outstanding reads still drain through the FIFO.

## Timing
- **Reset values.**
  - All strobes, acks, dvlds and tag_err are 0.
  - qdr_* address/data outputs and rd_data are 0.
  - tag_count=0; busy=0.
  - lp=B, so A wins the first tie.
- **Reset mid-operation.** Reset flushes the FIFO. Returns arriving after reset release, with the FIFO empty, set tag_err.
- **Grant to strobe.** A grant in cycle N produces the qdr strobe in N+1.
- **Per-channel throughput.** The earliest next grant on the same channel is N+2, giving a maximum of 1 strobe per 2 cycles per channel.
- **Read return latency.** qdr_rd_dvld in cycle M produces x_rd_dvld and rd_data in M+1. The arbiter adds 1 cycle to the controller's read latency on each side.
- **Ack is combinational.** The ack depends only on registered state and the current request inputs. Requesters must hold the request, address and data stable until ack. Deasserting a request before ack withdraws it.

## Test plan
- **Single read.** Reset, phy_rdy=1, A reads addr 0x00010 once.
  - Required: a_rd_ack in cycle N; qdr_rd_strb with addr 0x00010 in N+1.
  - Required: controller returns 0x123456789 in M; a_rd_dvld=1 with that data in M+1; b_rd_dvld stays 0.
- **Round-robin under contention.** A and B both continuously request reads for 12 cycles.
  - Required: acks alternate A,B,A,… on cycles 0,2,4,…; 6 strobes total.
  - Required: returns are steered in the same A,B order.
- **Concurrent channels.** A holds wr_req while B holds rd_req.
  - Required: a_wr_ack and b_rd_ack in the same cycle.
  - Required: qdr_wr_strb and qdr_rd_strb in the same following cycle, with correct addresses and data.
- **Tag FIFO full.** TAG_DEPTH=16; 16 reads are granted with no returns.
  - Required: the 17th request gets no ack.
  - Required: one qdr_rd_dvld frees a slot, and the ack is given in a later cycle, no earlier than the cycle after the pop.
- **phy_rdy gating.** phy_rdy=0 with requests pending.
  - Required: no acks and no strobes.
  - Required: with phy_rdy rising in cycle K, the first ack is in K.
- **Error path.** After reset, drive qdr_rd_dvld with no outstanding reads.
  - Required: tag_err=1 from the next cycle and held; no dvld asserted.
  - Required: reset clears tag_err.
